// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM states, parity selectors and the default word width.
// Used by both the transmit and receive paths.
package uart_pkg;

    localparam int UART_DATA_WIDTH = 8;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

endpackage

// File: rtl/uart_tx_frame_if.sv
// Host-side transmit request bus plus the serial line and busy flag.
// par_typ exists only when UART_TX_PARITY_EN is defined.
interface uart_tx_frame_if
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = UART_DATA_WIDTH
);

    logic [DATA_WIDTH-1:0] p_data;
    logic                  data_valid;
    logic [4:0]            prescale;
`ifdef UART_TX_PARITY_EN
    logic                  par_typ;
`endif
    logic                  tx_out;
    logic                  busy;

`ifdef UART_TX_PARITY_EN
    modport master (output p_data, data_valid, prescale, par_typ, input tx_out, busy);
    modport slave  (input p_data, data_valid, prescale, par_typ, output tx_out, busy);
`else
    modport master (output p_data, data_valid, prescale, input tx_out, busy);
    modport slave  (input p_data, data_valid, prescale, output tx_out, busy);
`endif

endinterface

// File: rtl/uart_tx_bit_timer.sv
// Bit-period timer: counts 0..prescale_q-1 while enabled and pulses bit_done on the last count.
module uart_tx_bit_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       enable,
    input  logic [4:0] prescale_q,
    output logic       bit_done
);

    logic [4:0] count;

    assign bit_done = enable && (count == prescale_q - 5'd1);

    // NOTE: asynchronous active-low reset; every register here gets a defined reset value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= bit_done ? 5'd0 : count + 5'd1;
        end
    end

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter: start bit, DATA_WIDTH data bits LSB first, optional parity, stop bit.
// Define UART_TX_PARITY_EN to add the par_typ input and a parity bit after the data bits.
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = UART_DATA_WIDTH
) (
    input logic            clk,
    input logic            rst,
    uart_tx_frame_if.slave bus
);

    localparam int              CNT_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    tx_state_t             state;
    logic [DATA_WIDTH-1:0] shreg;
    logic [DATA_WIDTH-1:0] shreg_next;
    logic [CNT_W-1:0]      bit_cnt;
    logic [4:0]            prescale_q;
    logic                  tx_q;
    logic                  busy_q;
    logic                  accept;
    logic                  bit_done;
`ifdef UART_TX_PARITY_EN
    logic                  par_bit;
`endif

    assign accept     = (state == IDLE) && bus.data_valid;
    assign shreg_next = shreg >> 1;
    assign bus.tx_out = tx_q;
    assign bus.busy   = busy_q;

    uart_tx_bit_timer u_timer (
        .clk        (clk),
        .rst        (rst),
        .clear      (accept),
        .enable     (state != IDLE),
        .prescale_q (prescale_q),
        .bit_done   (bit_done)
    );

    // Each transition loads tx_q with the level of the bit being entered, so the line
    // changes on the same edge as the state and stays free of input-to-output paths.
    // NOTE: sequential state uses non-blocking assignments only, so every read sees the pre-edge value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            shreg      <= '0;
            bit_cnt    <= '0;
            prescale_q <= 5'd1;
`ifdef UART_TX_PARITY_EN
            par_bit    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.data_valid) begin
                        state      <= START;
                        tx_q       <= 1'b0;
                        busy_q     <= 1'b1;
                        shreg      <= bus.p_data;
                        bit_cnt    <= '0;
                        prescale_q <= (bus.prescale == '0) ? 5'd1 : bus.prescale;
`ifdef UART_TX_PARITY_EN
                        par_bit    <= (^bus.p_data) ^ bus.par_typ;
`endif
                    end
                end
                START: begin
                    if (bit_done) begin
                        state <= DATA;
                        tx_q  <= shreg[0];
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        shreg <= shreg_next;
                        if (bit_cnt == LAST_BIT) begin
                            bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
                            state   <= PARITY;
                            tx_q    <= par_bit;
`else
                            state   <= STOP;
                            tx_q    <= 1'b1;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            tx_q    <= shreg_next[0];
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (bit_done) begin
                        state <= STOP;
                        tx_q  <= 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (bit_done) begin
                        state  <= IDLE;
                        tx_q   <= 1'b1;
                        busy_q <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    tx_q   <= 1'b1;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: queue-based line model checked every cycle, plus hand-computed frames.
// Frame captures pack bit i of the frame (start = bit 0) into bits[i]; unused upper bits read 1.
module tb_uart_tx_frame;
    import uart_pkg::*;

`ifdef UART_TX_PARITY_EN
    localparam int          NB        = 11;
    localparam logic [15:0] EXP_A5    = 16'hFD4A;
    localparam logic [15:0] EXP_A5_OD = 16'hFF4A;
    localparam logic [15:0] EXP_3C    = 16'hFC78;
    localparam logic [15:0] EXP_00    = 16'hFC00;
    localparam logic [15:0] EXP_FF    = 16'hFDFE;
    localparam logic [15:0] EXP_81    = 16'hFD02;
    localparam logic [15:0] EXP_55    = 16'hFCAA;
`else
    localparam int          NB        = 10;
    localparam logic [15:0] EXP_A5    = 16'hFF4A;
    localparam logic [15:0] EXP_3C    = 16'hFE78;
    localparam logic [15:0] EXP_00    = 16'hFE00;
    localparam logic [15:0] EXP_FF    = 16'hFFFE;
    localparam logic [15:0] EXP_81    = 16'hFF02;
    localparam logic [15:0] EXP_55    = 16'hFEAA;
`endif

    logic clk;
    logic rst;
    int   n_pass  = 0;
    int   n_total = 0;
    bit   cmp_en  = 1'b0;

    uart_tx_frame_if #(.DATA_WIDTH(8)) bus ();

    uart_tx_frame #(.DATA_WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Line model: on accept, the whole frame is expanded into one (tx, busy) sample per cycle.
    logic       m_tx;
    logic       m_busy;
    logic [1:0] m_q[$];

    always @(posedge clk or negedge rst) begin
        logic [1:0]  s;
        logic [10:0] fbits;
        int          nbits;
        int          bl;
        int          ones;
        if (!rst) begin
            m_q.delete();
            m_tx   <= 1'b1;
            m_busy <= 1'b0;
        end else if (m_q.size() != 0) begin
            s = m_q.pop_front();
            m_tx   <= s[1];
            m_busy <= s[0];
        end else if (!m_busy && bus.data_valid === 1'b1) begin
            bl    = (bus.prescale == 5'd0) ? 1 : int'(bus.prescale);
            ones  = 0;
            fbits = '1;
            fbits[0] = 1'b0;
            for (int i = 0; i < 8; i++) begin
                fbits[i+1] = bus.p_data[i];
                if (bus.p_data[i]) ones++;
            end
            nbits = 10;
`ifdef UART_TX_PARITY_EN
            fbits[9] = ((ones % 2) == 1) ^ bus.par_typ;
            nbits = 11;
`endif
            for (int b = 0; b < nbits; b++)
                for (int k = 0; k < bl; k++)
                    m_q.push_back({fbits[b], 1'b1});
            s = m_q.pop_front();
            m_tx   <= s[1];
            m_busy <= s[0];
        end else begin
            m_tx   <= 1'b1;
            m_busy <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("cycle_tx_out", {31'd0, bus.tx_out}, {31'd0, m_tx});
            check("cycle_busy", {31'd0, bus.busy}, {31'd0, m_busy});
        end
    end

    task automatic drive_pulse(input logic [7:0] d, input logic [4:0] ps);
        @(posedge clk);
        #1;
        bus.p_data     = d;
        bus.prescale   = ps;
        bus.data_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.data_valid = 1'b0;
    endtask

    // Called at a negedge; waits for busy, then samples mid-bit until busy falls.
    task automatic capture_frame(input int bl, output logic [15:0] bits, output int busy_len,
                                 output int gap);
        int t;
        t        = 0;
        bits     = '1;
        busy_len = 0;
        while (bus.busy !== 1'b1 && t < 400) begin
            t++;
            @(negedge clk);
        end
        gap = t;
        if (bus.busy !== 1'b1) begin
            check("busy_rise", {31'd0, bus.busy}, 32'd1);
            return;
        end
        for (int c = 0; c < 3000 && bus.busy === 1'b1; c++) begin
            if ((c % bl) == (bl / 2) && (c / bl) < 16) bits[c/bl] = bus.tx_out;
            busy_len++;
            @(negedge clk);
        end
        if (bus.busy !== 1'b0) check("busy_fall", {31'd0, bus.busy}, 32'd0);
    endtask

    task automatic run_frame(input logic [7:0] d, input logic [4:0] ps, output logic [15:0] bits,
                             output int busy_len);
        int gap;
        drive_pulse(d, ps);
        @(negedge clk);
        capture_frame((ps == 5'd0) ? 1 : int'(ps), bits, busy_len, gap);
    endtask

    logic [15:0] bits, bits2;
    int          len, len2, gap;

    initial begin
        bus.p_data     = 8'h00;
        bus.data_valid = 1'b0;
        bus.prescale   = 5'd8;
`ifdef UART_TX_PARITY_EN
        bus.par_typ    = PAR_EVEN;
`endif
        rst = 1'b1;
        #1 rst = 1'b0;
        #1 cmp_en = 1'b1;
        check("reset_tx_out", {31'd0, bus.tx_out}, 32'd1);
        check("reset_busy", {31'd0, bus.busy}, 32'd0);
        #20 rst = 1'b1;

        // T1 basic frame
        run_frame(8'hA5, 5'd8, bits, len);
        check("t1_bits", {16'd0, bits}, {16'd0, EXP_A5});
        check("t1_busy_len", len, NB * 8);

`ifdef UART_TX_PARITY_EN
        // T2 parity even / odd
        bus.par_typ = PAR_EVEN;
        run_frame(8'hA5, 5'd8, bits, len);
        check("t2_even_bits", {16'd0, bits}, {16'd0, EXP_A5});
        check("t2_even_parity", {31'd0, bits[9]}, 32'd0);
        bus.par_typ = PAR_ODD;
        run_frame(8'hA5, 5'd8, bits, len);
        check("t2_odd_bits", {16'd0, bits}, {16'd0, EXP_A5_OD});
        check("t2_odd_parity", {31'd0, bits[9]}, 32'd1);
        check("t2_busy_len", len, 88);
        bus.par_typ = PAR_EVEN;
`endif

        // T3 request while busy is dropped
        fork
            run_frame(8'h3C, 5'd8, bits, len);
            begin
                repeat (30) @(posedge clk);
                #1;
                bus.p_data     = 8'hFF;
                bus.data_valid = 1'b1;
                @(posedge clk);
                #1 bus.data_valid = 1'b0;
            end
        join
        check("t3_bits", {16'd0, bits}, {16'd0, EXP_3C});
        check("t3_busy_len", len, NB * 8);
        repeat (100) @(negedge clk);
        check("t3_idle_tx_out", {31'd0, bus.tx_out}, 32'd1);
        check("t3_idle_busy", {31'd0, bus.busy}, 32'd0);

        // T4 back-to-back with data_valid held high
        @(posedge clk);
        #1;
        bus.p_data     = 8'h00;
        bus.prescale   = 5'd16;
        bus.data_valid = 1'b1;
        @(posedge clk);
        #1 bus.p_data = 8'hFF;
        @(negedge clk);
        capture_frame(16, bits, len, gap);
        fork
            capture_frame(16, bits2, len2, gap);
            begin
                repeat (40) @(posedge clk);
                #1 bus.data_valid = 1'b0;
            end
        join
        check("t4_first_bits", {16'd0, bits}, {16'd0, EXP_00});
        check("t4_first_len", len, NB * 16);
        check("t4_idle_gap", gap, 1);
        check("t4_second_bits", {16'd0, bits2}, {16'd0, EXP_FF});
        check("t4_second_len", len2, NB * 16);

        // T5 reset during data bit 3
        drive_pulse(8'hA5, 5'd4);
        repeat (17) @(posedge clk);
        #1;
        check("t5_busy_before", {31'd0, bus.busy}, 32'd1);
        rst = 1'b0;
        #1;
        check("t5_reset_tx_out", {31'd0, bus.tx_out}, 32'd1);
        check("t5_reset_busy", {31'd0, bus.busy}, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #3 rst = 1'b1;
        run_frame(8'h81, 5'd4, bits, len);
        check("t5_new_bits", {16'd0, bits}, {16'd0, EXP_81});
        check("t5_new_len", len, NB * 4);

        // T6 minimum prescale
        run_frame(8'h55, 5'd0, bits, len);
        check("t6_p0_bits", {16'd0, bits}, {16'd0, EXP_55});
        check("t6_p0_len", len, NB);
        run_frame(8'h55, 5'd1, bits, len);
        check("t6_p1_bits", {16'd0, bits}, {16'd0, EXP_55});
        check("t6_p1_len", len, NB);

        repeat (5) @(negedge clk);
        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
